mux_rr_reg: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer; successor to the single-bit 2:1 gate-level mux.
- Adds per-channel valid/ready handshakes and a one-stage output register.
- Runtime mode: manual select, or round-robin arbitration across requesting channels.
- Sits between multiple producer streams and a single consumer, e.g. sharing one datapath among several sources.

---
 rtl/mux_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/mux_rr_reg.sv | 107 ++++++++++
 tb/tb_mux_rr_reg.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Mode encodings and a modulo increment shared by mux_rr_reg.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Explicit wrap so non-power-of-two channel counts stay in range.
    function automatic int unsigned mod_inc(input int unsigned value,
                                            input int unsigned modulus);
        return (value + 1 >= modulus) ? 0 : value + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter; the search starts at i_ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [SEL_W-1:0]    i_ptr,
    output logic                o_grant_valid,
    output logic [SEL_W-1:0]    o_grant_idx
);

    logic [2*CHANNELS-1:0] w_dbl;
    logic [CHANNELS-1:0]   w_rot;
    logic [SEL_W:0]        w_off;
    logic [SEL_W:0]        w_sum;

    // Rotate requests so bit 0 is the pointer channel, then take the lowest set bit.
    always_comb begin
        w_dbl = {i_req, i_req} >> i_ptr;
        w_rot = w_dbl[CHANNELS-1:0];
        w_off = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = (SEL_W+1)'(k);
            end
        end
        w_sum = {1'b0, i_ptr} + w_off;
        if (w_sum >= (SEL_W+1)'(CHANNELS)) begin
            w_sum = w_sum - (SEL_W+1)'(CHANNELS);
        end
        o_grant_valid = |i_req;
        o_grant_idx   = w_sum[SEL_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/mux_rr_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_rr_reg
//  Description : N-channel registered mux with valid/ready handshakes and
//                manual or round-robin channel selection.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_reg
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]       valid_in,
    output logic [CHANNELS-1:0]       ready_out,
    input  logic                      mode_in,
    input  logic [SEL_W-1:0]          sel_in,
    output logic [WIDTH-1:0]          y_out,
    output logic                      y_valid_out,
    output logic [SEL_W-1:0]          y_sel_out,
    input  logic                      y_ready_in
);

    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;
    logic [SEL_W-1:0] r_y_sel;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_can_load;
    logic             w_rr_valid;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_man_valid;
    logic             w_grant_valid;
    logic [SEL_W-1:0] w_grant;
    logic             w_xfer;
    logic [WIDTH-1:0] w_data_sel;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_arbiter (
        .i_req         (valid_in),
        .i_ptr         (r_rr_ptr),
        .o_grant_valid (w_rr_valid),
        .o_grant_idx   (w_rr_idx)
    );

    // Out-of-range select matches no channel, so it simply never grants.
    always_comb begin
        w_man_valid = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_in == SEL_W'(k) && valid_in[k]) begin
                w_man_valid = 1'b1;
            end
        end
    end

    assign w_can_load    = !r_y_valid || y_ready_in;
    assign w_grant_valid = (mode_in == MODE_RR) ? w_rr_valid : w_man_valid;
    assign w_grant       = (mode_in == MODE_RR) ? w_rr_idx   : sel_in;
    assign w_xfer        = w_can_load && w_grant_valid;

    always_comb begin
        w_data_sel = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_grant == SEL_W'(k)) begin
                w_data_sel = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_ready
            assign ready_out[k] = !rst_in && w_xfer && (w_grant == SEL_W'(k));
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_y_sel   <= '0;
            r_rr_ptr  <= '0;
        end else if (w_can_load) begin
            if (w_grant_valid) begin
                r_y       <= w_data_sel;
                r_y_sel   <= w_grant;
                r_y_valid <= 1'b1;
                if (mode_in == MODE_RR) begin
                    r_rr_ptr <= SEL_W'(mod_inc(32'(w_grant), CHANNELS));
                end
            end else begin
                r_y_valid <= 1'b0;
            end
        end
    end

    assign y_out       = r_y;
    assign y_valid_out = r_y_valid;
    assign y_sel_out   = r_y_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_rr_reg
//  Description : Directed bench for a 4-channel and a 3-channel mux_rr_reg
//                driven from shared stimulus, checked against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        yr;

    logic [3:0] rdy4;
    logic [7:0] y4;
    logic       yv4;
    logic [1:0] ys4;
    logic [2:0] rdy3;
    logic [7:0] y3;
    logic       yv3;
    logic [1:0] ys3;

    int n_vec = 0;
    int n_bad = 0;

    int         m_ptr   [2];
    logic       m_valid [2];
    logic [7:0] m_y     [2];
    int         m_sel   [2];
    logic [9:0] q4 [$];
    logic [9:0] q3 [$];

    always #5 clk = ~clk;

    mux_rr_reg #(.WIDTH(8), .CHANNELS(4)) dut4 (
        .clk_in (clk), .rst_in (rst), .data_in (data), .valid_in (valid),
        .ready_out (rdy4), .mode_in (mode), .sel_in (sel), .y_out (y4),
        .y_valid_out (yv4), .y_sel_out (ys4), .y_ready_in (yr)
    );

    mux_rr_reg #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk_in (clk), .rst_in (rst), .data_in (data[23:0]), .valid_in (valid[2:0]),
        .ready_out (rdy3), .mode_in (mode), .sel_in (sel), .y_out (y3),
        .y_valid_out (yv3), .y_sel_out (ys3), .y_ready_in (yr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int mgrant(input int n, input int ptr, input logic md,
                                  input int s, input logic [3:0] v);
        if (md == 1'b0) begin
            return (s < n && v[s]) ? s : -1;
        end
        for (int i = 0; i < n; i++) begin
            int c;
            c = (ptr + i) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic drv(input logic r, input logic md, input logic [1:0] s,
                       input logic [3:0] v, input logic y);
        rst   = r;
        mode  = md;
        sel   = s;
        valid = v;
        yr    = y;
        data  = $urandom;
    endtask

    task automatic cycle();
        int         g  [2];
        logic       can[2];
        logic       xf [2];
        logic [3:0] obs_r;
        logic [3:0] exp_r;
        logic [9:0] e;
        #1;
        for (int d = 0; d < 2; d++) begin
            g[d]   = mgrant(d ? 3 : 4, m_ptr[d], mode, int'(sel), valid);
            can[d] = !m_valid[d] || yr;
            xf[d]  = !rst && can[d] && (g[d] >= 0);
            exp_r  = xf[d] ? 4'(1 << g[d]) : 4'b0000;
            obs_r  = d ? {1'b0, rdy3} : rdy4;
            chk(d ? "ready3" : "ready4", 32'(obs_r), 32'(exp_r));
            if (xf[d]) begin
                e = {2'(g[d]), data[g[d]*8 +: 8]};
                if (d == 0) q4.push_back(e); else q3.push_back(e);
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_valid[d] = 1'b0;
                m_y[d]     = 8'h00;
                m_sel[d]   = 0;
                m_ptr[d]   = 0;
            end else if (can[d]) begin
                if (g[d] >= 0) begin
                    m_valid[d] = 1'b1;
                    m_y[d]     = data[g[d]*8 +: 8];
                    m_sel[d]   = g[d];
                    if (mode) m_ptr[d] = (g[d] + 1) % (d ? 3 : 4);
                end else begin
                    m_valid[d] = 1'b0;
                end
            end
        end
        #1;
        chk("y_valid4", 32'(yv4), 32'(m_valid[0]));
        chk("y_valid3", 32'(yv3), 32'(m_valid[1]));
        if (xf[0]) begin
            e = q4.pop_front();
            chk("y_out4", 32'(y4), 32'(e[7:0]));
            chk("y_sel4", 32'(ys4), 32'(e[9:8]));
        end else begin
            chk("y_hold4", 32'(y4), 32'(m_y[0]));
            chk("y_selh4", 32'(ys4), 32'(m_sel[0]));
        end
        if (xf[1]) begin
            e = q3.pop_front();
            chk("y_out3", 32'(y3), 32'(e[7:0]));
            chk("y_sel3", 32'(ys3), 32'(e[9:8]));
        end else begin
            chk("y_hold3", 32'(y3), 32'(m_y[1]));
            chk("y_selh3", 32'(ys3), 32'(m_sel[1]));
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_valid[d] = 1'b0; m_y[d] = 8'h00; m_sel[d] = 0;
        end
        // Reset with every channel requesting.
        drv(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1);
        cycle();
        cycle();
        chk("rst_y4", 32'(y4), 32'h0);
        chk("rst_yv3", 32'(yv3), 32'h0);
        // Round-robin fairness: 0,1,2,3,0,1 and 0,1,2,0,1,2.
        for (int i = 0; i < 6; i++) begin
            drv(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1);
            cycle();
        end
        // Manual select of channel 2 carrying A5.
        drv(1'b0, 1'b0, 2'd2, 4'b0100, 1'b1);
        data[23:16] = 8'hA5;
        cycle();
        chk("man_a5", 32'(y4), 32'hA5);
        drv(1'b0, 1'b0, 2'd2, 4'b0000, 1'b1);
        cycle();
        // Skip and wrap: grant 2 sets ptr 3; then only ch1; then only ch0.
        drv(1'b0, 1'b1, 2'd0, 4'b0100, 1'b1); cycle();
        drv(1'b0, 1'b1, 2'd0, 4'b0010, 1'b1); cycle();
        drv(1'b0, 1'b1, 2'd0, 4'b0001, 1'b1); cycle();
        // Backpressure for five cycles, then release.
        drv(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1); cycle();
        for (int i = 0; i < 5; i++) begin
            drv(1'b0, 1'b1, 2'd0, 4'b1111, 1'b0);
            cycle();
        end
        drv(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1); cycle();
        drv(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1); cycle();
        // Select 3 is out of range only for the 3-channel instance.
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 1'b0, 2'd3, 4'b1111, 1'b1);
            cycle();
        end
        // Reset while a word is held under backpressure.
        drv(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1); cycle();
        drv(1'b0, 1'b1, 2'd0, 4'b1111, 1'b0); cycle();
        drv(1'b1, 1'b1, 2'd0, 4'b1111, 1'b0); cycle();
        // Mixed traffic with mode changes and random backpressure.
        for (int i = 0; i < 40; i++) begin
            drv(1'b0, 1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0));
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
